oh_fifo_sync_ctrl: RTL and testbench
====================================

Name: oh_fifo_sync_ctrl

Overview:
- Single-clock FIFO controller that drives a dual-port registered-read RAM (oh_memory_ram port set, both RAM clocks tied to clk).
- Generates RAM write and read pointers and occupancy flags.
- Hides the RAM's one-cycle read latency behind a 2-entry output buffer, giving a first-word-fall-through (valid/pop) read interface.
- Sits between the packet producer and the RAM in the EMesh bridge transaction queues.

Parameters:
DW, 104, data width; equals the RAM DW.
DEPTH, 32, RAM entries; must equal 2**AW.
AW, 5, RAM address width.
PROG_FULL, 24, RAM occupancy at or above which prog_full asserts.

Ports:
clk  input  1  clock for the controller and both RAM ports
reset  input  1  synchronous active-high reset
wr_en  input  1  push request
din  input  DW  push data
full  output  1  RAM occupancy == DEPTH
prog_full  output  1  RAM occupancy >= PROG_FULL
rd_en  input  1  pop; legal only when valid=1
dout  output  DW  head-of-queue data
valid  output  1  dout holds an entry
count  output  AW+2  total entries held (RAM + in-flight + output buffer)
overflow  output  1  one-cycle pulse: push while full
underflow  output  1  one-cycle pulse: pop while valid=0
mem_wr_en  output  1  to RAM wr_en
mem_wr_addr  output  AW  to RAM wr_addr
mem_wr_wem  output  DW  to RAM wr_wem; constant all ones
mem_wr_din  output  DW  to RAM wr_din; equals din
mem_rd_en  output  1  to RAM rd_en
mem_rd_addr  output  AW  to RAM rd_addr
mem_rd_dout  input  DW  from RAM rd_dout; valid the cycle after mem_rd_en

Behaviour:
- Reset (synchronous, clk edge with reset=1): wr_ptr=0, rd_ptr=0, ram_cnt=0, inflight=0, ob_cnt=0.
- Reset output values: valid=0, full=0, prog_full=0, count=0, overflow=0, underflow=0, dout=0.
- Reset mid-operation discards all contents, including in-flight read data. mem_rd_en and mem_wr_en are 0 while reset=1.
- Push:
  - Accepted when wr_en & ~full. mem_wr_en = wr_en & ~full (combinational), mem_wr_addr = wr_ptr.
  - On accept, wr_ptr increments modulo DEPTH (natural AW-bit wrap).
  - wr_en & full: write dropped, no pointer change, overflow pulses for 1 cycle.
- Read issue:
  - Combinational: mem_rd_en = (ram_cnt != 0) & ((ob_cnt + inflight - pop) < 2), where pop = rd_en & valid. mem_rd_addr = rd_ptr.
  - On issue, rd_ptr increments modulo DEPTH and inflight<=1 for the next cycle; otherwise inflight<=0.
  - When inflight=1, mem_rd_dout is captured into the output buffer at that cycle's edge.
- Output buffer (2 entries, FIFO ordered):
  - dout = entry 0; valid = (ob_cnt != 0). dout is a register, not RAM output.
  - Pop with simultaneous capture: entry 1 (or the captured word if ob_cnt=1) moves to entry 0 in the same edge.
  - rd_en with valid=0: ignored, underflow pulses for 1 cycle.
- Counters:
  - ram_cnt next = ram_cnt + push_accept - mem_rd_en. Range 0..DEPTH, width AW+1.
  - full = (ram_cnt == DEPTH); prog_full = (ram_cnt >= PROG_FULL); both registered-state derived, no combinational path from wr_en/rd_en.
  - count = ram_cnt + inflight + ob_cnt; maximum DEPTH+2.
- Latency: push accepted at edge t gives valid=1 after edge t+2 when the queue was empty. Throughput is one push and one pop per cycle sustained.
- RAM read and write never target the same address in one cycle: a read needs ram_cnt != 0, which is registered state.
- Simultaneous push and pop while full: the push is rejected (full is RAM-side only); the pop is served from the output buffer.
- Pointer wrap: after DEPTH pushes, wr_ptr returns to 0 with no gap. Ordering is preserved across wrap.

Test Plan:
- Reset, then push 0xA1 at cycle 0 -> valid=1 and dout=0xA1 from cycle 2, count=1. Pop at cycle 3 -> valid=0, count=0.
- Push 34 words 0..33 with no pops -> count=34, full=1 once ram_cnt=32, prog_full=1 after 26 pushes. 35th push -> overflow pulse, count stays 34.
- Fill, then pop every cycle while pushing whenever ~full for 200 cycles -> output sequence strictly increasing with no gaps, one pop per cycle after the initial 2-cycle latency.
- Push and pop 100 words continuously -> pointers wrap 3 times, order preserved, mem_wr_addr == mem_rd_addr never in the same cycle.
- Pop with valid=0 -> underflow pulse, count unchanged. Push while full with a simultaneous pop -> overflow pulse, pop served, count decrements by 1.
- Assert reset for 1 cycle while inflight=1 and count=10 -> count=0 and valid=0 next cycle. The next push 0x55 appears on dout 2 cycles later with no stale data.

Source files
------------

// File: rtl/oh_fifo_sync_ctrl.sv
// Single-clock FIFO controller for a registered-read dual-port RAM.
// A 2-entry output buffer hides the RAM read latency, giving a first-word-fall-through interface.
module oh_fifo_sync_ctrl #(
    parameter int DW        = 104,
    parameter int DEPTH     = 32,
    parameter int AW        = 5,
    parameter int PROG_FULL = 24
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [DW-1:0] din,
    output logic          full,
    output logic          prog_full,
    input  logic          rd_en,
    output logic [DW-1:0] dout,
    output logic          valid,
    output logic [AW+1:0] count,
    output logic          overflow,
    output logic          underflow,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_wr_addr,
    output logic [DW-1:0] mem_wr_wem,
    output logic [DW-1:0] mem_wr_din,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_rd_addr,
    input  logic [DW-1:0] mem_rd_dout
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] PFULL_C = (AW+1)'(PROG_FULL);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   ram_cnt_q, ram_cnt_d;
    logic          inflight_q, inflight_d;
    logic [1:0]    ob_cnt_q, ob_cnt_d;
    logic [DW-1:0] ob0_q, ob0_d;
    logic [DW-1:0] ob1_q, ob1_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic          push_s;
    logic          pop_s;
    logic          issue_s;
    logic [2:0]    ob_pend_s;

    assign full      = (ram_cnt_q == DEPTH_C);
    assign prog_full = (ram_cnt_q >= PFULL_C);
    assign valid     = (ob_cnt_q != 2'd0);
    assign dout      = ob0_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign count     = {1'b0, ram_cnt_q} + (AW+2)'(inflight_q) + (AW+2)'(ob_cnt_q);

    assign mem_wr_en   = push_s;
    assign mem_wr_addr = wr_ptr_q;
    assign mem_wr_wem  = {DW{1'b1}};
    assign mem_wr_din  = din;
    assign mem_rd_en   = issue_s;
    assign mem_rd_addr = rd_ptr_q;

    // Next-state logic: push/pop qualification, read issue and output buffer update.
    always_comb begin
        push_s    = wr_en & ~full & ~reset;
        pop_s     = rd_en & valid;
        // Entries the output buffer will hold once the pop and pending capture settle.
        ob_pend_s = {1'b0, ob_cnt_q} + {2'b00, inflight_q} - {2'b00, pop_s};
        issue_s   = ~reset & (ram_cnt_q != {(AW+1){1'b0}}) & (ob_pend_s < 3'd2);

        wr_ptr_d    = push_s  ? wr_ptr_q + {{(AW-1){1'b0}}, 1'b1} : wr_ptr_q;
        rd_ptr_d    = issue_s ? rd_ptr_q + {{(AW-1){1'b0}}, 1'b1} : rd_ptr_q;
        ram_cnt_d   = ram_cnt_q + (AW+1)'(push_s) - (AW+1)'(issue_s);
        inflight_d  = issue_s;
        overflow_d  = wr_en & full;
        underflow_d = rd_en & ~valid;

        ob0_d    = ob0_q;
        ob1_d    = ob1_q;
        ob_cnt_d = ob_cnt_q;
        if (pop_s) begin
            ob0_d    = ob1_q;
            ob_cnt_d = ob_cnt_q - 2'd1;
        end else begin
            ob_cnt_d = ob_cnt_q;
        end
        if (inflight_q) begin
            if (ob_cnt_d == 2'd0) begin
                ob0_d = mem_rd_dout;
            end else begin
                ob1_d = mem_rd_dout;
            end
            ob_cnt_d = ob_cnt_d + 2'd1;
        end else begin
            ob_cnt_d = ob_cnt_d;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            ram_cnt_q   <= {(AW+1){1'b0}};
            inflight_q  <= 1'b0;
            ob_cnt_q    <= 2'd0;
            ob0_q       <= {DW{1'b0}};
            ob1_q       <= {DW{1'b0}};
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_cnt_q   <= ram_cnt_d;
            inflight_q  <= inflight_d;
            ob_cnt_q    <= ob_cnt_d;
            ob0_q       <= ob0_d;
            ob1_q       <= ob1_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_oh_fifo_sync_ctrl.sv
// Directed self-checking bench for oh_fifo_sync_ctrl with a behavioural registered-read RAM.
module tb_oh_fifo_sync_ctrl;

    localparam int DW = 104;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [DW-1:0] din;
    logic          full;
    logic          prog_full;
    logic          rd_en;
    logic [DW-1:0] dout;
    logic          valid;
    logic [AW+1:0] count;
    logic          overflow;
    logic          underflow;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_wr_wem;
    logic [DW-1:0] mem_wr_din;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_dout;

    logic [DW-1:0] ram [32];

    int tests = 0;
    int fails = 0;
    int nxt_push;
    int exp_pop;
    int pushed;
    int popped;

    oh_fifo_sync_ctrl #(.DW(DW), .DEPTH(32), .AW(AW), .PROG_FULL(24)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .din(din), .full(full),
        .prog_full(prog_full), .rd_en(rd_en), .dout(dout), .valid(valid),
        .count(count), .overflow(overflow), .underflow(underflow),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_wem(mem_wr_wem),
        .mem_wr_din(mem_wr_din), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_dout(mem_rd_dout)
    );

    always #5 clk = ~clk;

    // Registered-read dual-port RAM model.
    always @(posedge clk) begin
        if (mem_wr_en) ram[mem_wr_addr] <= mem_wr_din;
        if (mem_rd_en) mem_rd_dout <= ram[mem_rd_addr];
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; wr_en = 1'b1; din = '0; rd_en = 1'b0;
        #1;
        chk("wr_blocked_in_reset", mem_wr_en, 1'b0);
        step(); step();
        wr_en = 1'b0;
        chk("rst_valid", valid, 1'b0);
        chk("rst_count", count, 0);
        chk("rst_full", full, 1'b0);
        chk("rst_prog_full", prog_full, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_underflow", underflow, 1'b0);
        chk("rst_dout", dout, 0);
        reset = 1'b0;

        // Single word: latency two edges
        wr_en = 1'b1; din = 104'hA1;
        #1;
        chk("first_mem_wr_en", mem_wr_en, 1'b1);
        chk("first_wr_addr", mem_wr_addr, 0);
        chk("wem_ones", mem_wr_wem, {DW{1'b1}});
        chk("wr_din", mem_wr_din, 104'hA1);
        step(); wr_en = 1'b0;
        chk("a1_valid_t0", valid, 1'b0);
        chk("a1_count_t0", count, 1);
        step();
        chk("a1_valid_t1", valid, 1'b0);
        chk("a1_count_t1", count, 1);
        step();
        chk("a1_valid_t2", valid, 1'b1);
        chk("a1_dout", dout, 104'hA1);
        chk("a1_count_t2", count, 1);
        rd_en = 1'b1;
        step();
        chk("a1_pop_valid", valid, 1'b0);
        chk("a1_pop_count", count, 0);

        // Underflow
        step();
        chk("underflow_pulse", underflow, 1'b1);
        chk("underflow_count", count, 0);
        rd_en = 1'b0;
        step();
        chk("underflow_clear", underflow, 1'b0);

        // Fill with 34 words
        for (int i = 0; i < 34; i++) begin
            wr_en = 1'b1; din = DW'(i);
            step();
            if (i == 24) chk("prog_full_25", prog_full, 1'b0);
            if (i == 25) chk("prog_full_26", prog_full, 1'b1);
            if (i == 32) chk("full_33", full, 1'b0);
        end
        chk("fill_full", full, 1'b1);
        chk("fill_count", count, 34);
        chk("fill_dout", dout, 0);
        din = 104'd99;
        #1;
        chk("full_wr_blocked", mem_wr_en, 1'b0);
        step();
        chk("overflow_pulse", overflow, 1'b1);
        chk("overflow_count", count, 34);
        wr_en = 1'b0;
        step();
        chk("overflow_clear", overflow, 1'b0);

        // Push while full with simultaneous pop
        wr_en = 1'b1; rd_en = 1'b1; din = 104'd98;
        step();
        chk("fullpop_overflow", overflow, 1'b1);
        chk("fullpop_count", count, 33);
        chk("fullpop_dout", dout, 1);

        // Sustained pop every cycle, push whenever not full
        nxt_push = 34; exp_pop = 1;
        for (int k = 0; k < 200; k++) begin
            rd_en = 1'b1; wr_en = ~full; din = DW'(nxt_push);
            chk("stream_valid", valid, 1'b1);
            chk("stream_dout", dout, DW'(exp_pop));
            if (mem_wr_en && mem_rd_en) chk("stream_addr_sep", mem_wr_addr != mem_rd_addr, 1'b1);
            step();
            exp_pop++;
            if (wr_en) nxt_push++;
        end
        wr_en = 1'b0;
        for (int k = 0; k < 100 && exp_pop < nxt_push; k++) begin
            chk("drain_valid", valid, 1'b1);
            chk("drain_dout", dout, DW'(exp_pop));
            step();
            exp_pop++;
        end
        chk("drain_done", exp_pop, nxt_push);
        rd_en = 1'b0;
        chk("drain_count", count, 0);
        chk("drain_valid_low", valid, 1'b0);

        // 100 words push/pop continuously from empty
        pushed = 0; popped = 0;
        for (int k = 0; k < 120 && popped < 100; k++) begin
            wr_en = (pushed < 100); din = DW'(200 + pushed);
            rd_en = valid;
            if (valid) chk("cont_dout", dout, DW'(200 + popped));
            if (mem_wr_en && mem_rd_en) chk("cont_addr_sep", mem_wr_addr != mem_rd_addr, 1'b1);
            step();
            if (wr_en) pushed++;
            if (rd_en) popped++;
        end
        wr_en = 1'b0; rd_en = 1'b0;
        chk("cont_popped", popped, 100);
        chk("cont_count", count, 0);

        // Reset with a read in flight
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1; din = DW'(300 + i);
            step();
        end
        chk("pre_rst_count10", count, 10);
        rd_en = 1'b1; din = 104'd310;
        #1;
        chk("pre_rst_issue", mem_rd_en, 1'b1);
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("pre_rst_count", count, 10);
        chk("pre_rst_dout", dout, 301);
        reset = 1'b1;
        #1;
        chk("rd_blocked_in_reset", mem_rd_en, 1'b0);
        step();
        reset = 1'b0;
        chk("post_rst_count", count, 0);
        chk("post_rst_valid", valid, 1'b0);
        chk("post_rst_dout", dout, 0);
        wr_en = 1'b1; din = 104'h55;
        #1;
        chk("post_rst_wr_addr", mem_wr_addr, 0);
        step(); wr_en = 1'b0;
        step();
        chk("p55_valid_t1", valid, 1'b0);
        step();
        chk("p55_valid_t2", valid, 1'b1);
        chk("p55_dout", dout, 104'h55);
        chk("p55_count", count, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
